data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// +----------------------------------------------------------------------------+
// | Module   : data_sram_resp                                                  |
// | Brief    : Single-port 32-bit word SRAM with byte-lane writes, 1-cycle     |
// |            read response, out-of-range error flag and access counters.     |
// |            An optional zero-clear walk runs after reset (INIT_ZERO=1).     |
// |            Defining DATA_SRAM_WRITE_FIRST_EN makes write accesses return   |
// |            the merged post-write word. Without it they return read-first.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_sram_resp #(
    parameter int ADDR_W    = 10,
    parameter int INIT_ZERO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        rdata_vld,
    output logic        busy,
    output logic        addr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int                c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;
    localparam logic [ADDR_W-1:0] c_IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]       c_CNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              w_clr_we;

    logic [31:0]       r_mem [0:c_DEPTH-1];

    logic [31:0]       r_rdata;
    logic              r_rdata_vld;
    logic              r_addr_err;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;

    logic [ADDR_W-1:0] w_idx;
    logic              w_in_range;
    logic              w_acc;
    logic              w_is_wr;
    logic              w_wr_en;
    logic [31:0]       w_old;
    logic [31:0]       w_merged;
    logic [31:0]       w_resp;

    // ------------------------------------------------------------------
    // Clear-walk FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (INIT_ZERO != 0) ? ST_CLEAR : ST_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + c_IDX_ONE;
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    // Upper address bits must be zero; they are never folded into the index.
    assign w_idx      = sram_addr[ADDR_W+1:2];
    assign w_in_range = ((sram_addr >> (ADDR_W + 2)) == 32'd0);
    assign w_acc      = sram_en & ~busy;
    assign w_is_wr    = |sram_wen;
    assign w_wr_en    = w_acc & w_is_wr & w_in_range & ~rst;
    assign w_old      = r_mem[w_idx];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_merged[8*g +: 8] = sram_wen[g] ? sram_wdata[8*g +: 8]
                                                : w_old[8*g +: 8];
    end

`ifdef DATA_SRAM_WRITE_FIRST_EN
    assign w_resp = !w_in_range ? 32'h0 : (w_is_wr ? w_merged : w_old);
`else
    assign w_resp = !w_in_range ? 32'h0 : w_old;
`endif

    // ------------------------------------------------------------------
    // Storage: the clear walk owns the write port while busy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_idx] <= 32'h0;
        end else if (w_wr_en) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // ------------------------------------------------------------------
    // Response, error flag and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata     <= 32'h0;
            r_rdata_vld <= 1'b0;
            r_addr_err  <= 1'b0;
            r_rd_cnt    <= 32'h0;
            r_wr_cnt    <= 32'h0;
        end else begin
            r_rdata_vld <= w_acc;
            if (w_acc) begin
                r_rdata <= w_resp;
                if (!w_in_range) begin
                    r_addr_err <= 1'b1;
                end
                if (w_is_wr) begin
                    if (r_wr_cnt != c_CNT_MAX) begin
                        r_wr_cnt <= r_wr_cnt + 32'd1;
                    end
                end else begin
                    if (r_rd_cnt != c_CNT_MAX) begin
                        r_rd_cnt <= r_rd_cnt + 32'd1;
                    end
                end
            end
        end
    end

    assign sram_rdata = r_rdata;
    assign rdata_vld  = r_rdata_vld;
    assign addr_err   = r_addr_err;
    assign rd_cnt     = r_rd_cnt;
    assign wr_cnt     = r_wr_cnt;

endmodule

`default_nettype wire
